// File: rtl/freq_bcd_scan_if.sv
// Display-side bus of the frequency counter: binary frequency in, packed BCD,
// overflow flag and multiplexed 7-segment drive out.
interface freq_bcd_scan_if;
  logic [31:0] freq;
  logic [31:0] bcd;
  logic        bcd_valid;
  logic        ovf;
  logic [7:0]  seg;
  logic [7:0]  sel;

  modport master (output freq, input bcd, bcd_valid, ovf, seg, sel);
  modport slave  (input freq, output bcd, bcd_valid, ovf, seg, sel);
endinterface

// File: rtl/freq_bcd_scan.sv
// Settles and clamps a binary frequency, converts it to 8-digit BCD by double-dabble
// and scans it onto a common-anode 7-segment display. FREQ_LZB_EN enables leading-zero blanking.
module freq_bcd_scan #(
  parameter int SCAN_DIV   = 48_000,
  parameter int STABLE_CYC = 4
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  freq_bcd_scan_if.slave  bus
);

  localparam logic [31:0] MAX_VAL = 32'd99_999_999;
  localparam int          SCW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int          STW     = $clog2(STABLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state;
  logic [31:0]      q1, q2, last_raw;
  logic [STW-1:0]   stab_cnt;
  logic [58:0]      sh, sh_adj;
  logic [4:0]       bit_cnt;
  logic             ovf_lat;
  logic [SCW-1:0]   scan_cnt;
  logic [2:0]       dig_idx;

  logic             stable, over, start, blank;
  logic [26:0]      clamped;
  logic [3:0]       nib;

  assign stable  = (stab_cnt == STW'(STABLE_CYC));
  assign over    = (q2 > MAX_VAL);
  assign clamped = over ? MAX_VAL[26:0] : q2[26:0];
  assign start   = (state == IDLE) && stable && (q2 != last_raw);

  // Add-3 correction on every BCD nibble of the shift register before each shift.
  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sh_adj = sh;
    for (int i = 0; i < 8; i++) begin
      if (sh[27 + 4*i +: 4] >= 4'd5)
        sh_adj[27 + 4*i +: 4] = sh[27 + 4*i +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      q1            <= '0;
      q2            <= '0;
      stab_cnt      <= '0;
      last_raw      <= '0;
      state         <= IDLE;
      sh            <= '0;
      bit_cnt       <= '0;
      ovf_lat       <= 1'b0;
      bus.bcd       <= '0;
      bus.ovf       <= 1'b0;
      bus.bcd_valid <= 1'b0;
    end else begin
      q1 <= bus.freq;
      q2 <= q1;
      if (q1 == q2) begin
        if (!stable) stab_cnt <= stab_cnt + 1'b1;
      end else begin
        stab_cnt <= '0;
      end

      bus.bcd_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sh       <= {32'b0, clamped};
          last_raw <= q2;
          ovf_lat  <= over;
          bit_cnt  <= '0;
          state    <= CONV;
        end
        CONV: begin
          sh      <= sh_adj << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 5'd26) state <= DONE;
        end
        DONE: begin
          bus.bcd       <= sh[58:27];
          bus.ovf       <= ovf_lat;
          bus.bcd_valid <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [7:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign nib = bus.bcd[{dig_idx, 2'b00} +: 4];

`ifdef FREQ_LZB_EN
  logic [2:0] msd;

  // Index of the most significant nonzero digit; digit 0 is always lit.
  always_comb begin
    msd = '0;
    for (int i = 1; i < 8; i++) begin
      if (bus.bcd[4*i +: 4] != 4'd0) msd = 3'(i);
    end
  end
  assign blank = (dig_idx > msd);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      bus.seg  <= 8'hFF;
      bus.sel  <= 8'hFF;
    end else begin
      if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        dig_idx  <= dig_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      bus.sel <= ~(8'd1 << dig_idx);
      bus.seg <= blank ? 8'hFF : decode(nib);
    end
  end

endmodule

// File: tb/tb_freq_bcd_scan.sv
// Directed bench for freq_bcd_scan: a decimal-arithmetic model of the displayed value and
// scan position is compared against the DUT every cycle, plus literal spot checks.
module tb_freq_bcd_scan;
  localparam int SD = 4;
  localparam int SC = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  freq_bcd_scan_if bus ();

  freq_bcd_scan #(.SCAN_DIV(SD), .STABLE_CYC(SC)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int unsigned val;
    bit          ovf;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_of(input int unsigned v, input int d);
    int unsigned p;
    int unsigned dig;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    dig = (v / p) % 10;
`ifdef FREQ_LZB_EN
    if (d > 0 && v < p) return 8'hFF;
`endif
    case (dig)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Model: value on the display, and cycles since reset release for the scan position.
  logic        rst_q = 1'b0;
  bit          armed = 1'b0;
  int          k = 0;
  int unsigned model_val = 0;
  bit          model_ovf = 1'b0;

  always @(posedge clk) begin
    rst_q = rst_n;
    armed = 1'b1;
  end

  always @(negedge clk) begin
    int unsigned prev;
    int          d;
    logic [7:0]  es;
    exp_t        e;
    if (armed) begin
      if (!rst_q) begin
        k         = 0;
        model_val = 0;
        model_ovf = 1'b0;
        check("reset bcd", bus.bcd, 32'd0);
        check("reset bcd_valid", 32'(bus.bcd_valid), 32'd0);
        check("reset ovf", 32'(bus.ovf), 32'd0);
        check("reset seg", 32'(bus.seg), 32'hFF);
        check("reset sel", 32'(bus.sel), 32'hFF);
      end else begin
        prev = model_val;
        k++;
        if (exp_q.size() == 0) begin
          check("idle bcd_valid", 32'(bus.bcd_valid), 32'd0);
        end else if (bus.bcd_valid) begin
          e         = exp_q.pop_front();
          model_val = e.val;
          model_ovf = e.ovf;
        end
        d  = ((k - 1) / SD) % 8;
        es = ~(8'd1 << d);
        check("bcd", bus.bcd, to_bcd(model_val));
        check("ovf", 32'(bus.ovf), 32'(model_ovf));
        check("sel", 32'(bus.sel), 32'(es));
        check("seg", 32'(bus.seg), 32'(seg_of(prev, d)));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (bus.bcd_valid) break;
      if (n >= maxc) begin
        vectors++;
        miscompares++;
        $display("FAIL bcd_valid timeout: got none after %0d cycles, required a pulse", n);
        break;
      end
    end
  endtask

  task automatic expect_conv(input int unsigned v, input bit o);
    exp_t e;
    e.val = v;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [7:0] cap [8];

    for (int i = 0; i < 8; i++) cap[i] = 8'h00;
    bus.freq = 32'd0;
    rst_n    = 1'b0;
    tick(3);
    check("lit reset bcd", bus.bcd, 32'd0);
    check("lit reset sel", 32'(bus.sel), 32'hFF);
    check("lit reset seg", 32'(bus.seg), 32'hFF);

    rst_n = 1'b1;
    tick(1);
    check("lit first sel", 32'(bus.sel), 32'hFE);
    check("lit first seg", 32'(bus.seg), 32'hC0);
    tick(20);

    // Nominal conversion and latency from freq change to pulse.
    expect_conv(12_345_678, 1'b0);
    bus.freq = 32'd12_345_678;
    wait_valid(100, n);
    check("lit latency", 32'(n), 32'(2 + SC + 29));
    check("lit nominal bcd", bus.bcd, 32'h1234_5678);
    check("lit nominal ovf", 32'(bus.ovf), 32'd0);

    // Overflow clamp.
    expect_conv(99_999_999, 1'b1);
    bus.freq = 32'd150_000_000;
    wait_valid(100, n);
    check("lit ovf bcd", bus.bcd, 32'h9999_9999);
    check("lit ovf flag", 32'(bus.ovf), 32'd1);
    expect_conv(99_999_999, 1'b1);
    bus.freq = 32'hFFFF_FFFF;
    wait_valid(100, n);
    check("lit max bcd", bus.bcd, 32'h9999_9999);
    check("lit max ovf", 32'(bus.ovf), 32'd1);
    expect_conv(99_999_999, 1'b0);
    bus.freq = 32'd99_999_999;
    wait_valid(100, n);
    check("lit limit bcd", bus.bcd, 32'h9999_9999);
    check("lit limit ovf", 32'(bus.ovf), 32'd0);

    // Settle filter: toggling input must never convert.
    for (int i = 0; i < 50; i++) begin
      bus.freq = 32'd1000;
      tick(2);
      bus.freq = 32'd2000;
      tick(2);
    end
    expect_conv(2000, 1'b0);
    wait_valid(100, n);
    check("lit settle bcd", bus.bcd, 32'h0000_2000);

    // Scan and blanking.
    expect_conv(507, 1'b0);
    bus.freq = 32'd507;
    wait_valid(100, n);
    tick(2);
    for (int c = 0; c < 9 * SD; c++) begin
      for (int d = 0; d < 8; d++)
        if (bus.sel == ~(8'd1 << d)) cap[d] = bus.seg;
      tick(1);
    end
    check("lit scan d0", 32'(cap[0]), 32'hF8);
    check("lit scan d1", 32'(cap[1]), 32'hC0);
    check("lit scan d2", 32'(cap[2]), 32'h92);
`ifdef FREQ_LZB_EN
    check("lit scan d3", 32'(cap[3]), 32'hFF);
    check("lit scan d7", 32'(cap[7]), 32'hFF);
`else
    check("lit scan d3", 32'(cap[3]), 32'hC0);
    check("lit scan d7", 32'(cap[7]), 32'hC0);
`endif

    // Reset in the middle of a conversion: no pulse for the aborted value.
    bus.freq = 32'd31_337;
    tick(2 + SC + 11);
    rst_n    = 1'b0;
    bus.freq = 32'd42;
    tick(3);
    check("lit midrst bcd", bus.bcd, 32'd0);
    check("lit midrst sel", 32'(bus.sel), 32'hFF);
    rst_n = 1'b1;
    expect_conv(42, 1'b0);
    wait_valid(100, n);
    check("lit midrst latency", 32'(n), 32'(2 + SC + 29));
    check("lit after rst bcd", bus.bcd, 32'h0000_0042);

    // Input change while converting is picked up by a second conversion.
    expect_conv(5, 1'b0);
    bus.freq = 32'd5;
    tick(12);
    expect_conv(7, 1'b0);
    bus.freq = 32'd7;
    wait_valid(100, n);
    check("lit first of two", bus.bcd, 32'h0000_0005);
    wait_valid(100, n);
    check("lit second of two", bus.bcd, 32'h0000_0007);
    tick(10);
    check("lit queue drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
